hazard_scoreboard: RTL

//  Producer-side companion to the EX-stage forwarding logic. It records every destination register

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage to scoreboard bundle: the decoded instruction fields go in, and stall/issue control plus status come back.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [ADDR_W-1:0]      id_rs;
    logic [ADDR_W-1:0]      id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic [ADDR_W-1:0]      id_rd;
    logic                   id_reg_write;
    logic                   id_is_load;
    logic                   id_is_mult;
    logic                   flush;
    logic                   stall;
    logic                   issue;
    logic [NUM_REGS-1:0]    busy_mask;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_is_load, id_is_mult, flush,
        input  stall, issue, busy_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_is_load, id_is_mult, flush,
        output stall, issue, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight destination registers with per-register countdowns until forwardable;
// stalls ID on RAW or WAW hazards and counts stall cycles.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int LOAD_DELAY  = 1,
    parameter int MULT_DELAY  = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int MAX_DELAY = (LOAD_DELAY > MULT_DELAY) ? LOAD_DELAY : MULT_DELAY;
    localparam int CNT_W     = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);

    logic [CNT_W-1:0]       cnt_q [NUM_REGS];
    logic [CNT_W-1:0]       cnt_d [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic [STALL_CNT_W-1:0] stall_count_d;
    logic [NUM_REGS-1:0]    busy_vec;

    logic [CNT_W-1:0] new_delay;
    logic             raw_rs;
    logic             raw_rt;
    logic             waw;
    logic             stall_w;
    logic             issue_w;
    logic             wr_en;

    always_comb begin
        if (sb.id_is_mult) begin
            new_delay = CNT_W'(MULT_DELAY);
        end else if (sb.id_is_load) begin
            new_delay = CNT_W'(LOAD_DELAY);
        end else begin
            new_delay = '0;
        end
    end

    // An older producer finishing after a younger writer of the same rd would clobber it: WAW stall.
    always_comb begin
        raw_rs  = sb.id_uses_rs && (sb.id_rs != '0) && (cnt_q[sb.id_rs] != '0);
        raw_rt  = sb.id_uses_rt && (sb.id_rt != '0) && (cnt_q[sb.id_rt] != '0);
        waw     = sb.id_reg_write && (sb.id_rd != '0) && (cnt_q[sb.id_rd] > new_delay);
        stall_w = sb.id_valid && !sb.flush && (raw_rs || raw_rt || waw);
        issue_w = sb.id_valid && !sb.flush && !stall_w;
        wr_en   = issue_w && sb.id_reg_write && (sb.id_rd != '0);
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
            if (wr_en && (sb.id_rd == ADDR_W'(i))) begin
                cnt_d[i] = new_delay;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_w && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_count_q <= stall_count_d;
        end
    end

    // busy_mask comes straight from the counters so it has no path from the ID inputs.
    assign busy_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            assign busy_vec[gi] = (cnt_q[gi] != '0);
        end
    endgenerate

    assign sb.busy_mask   = busy_vec;
    assign sb.stall       = stall_w;
    assign sb.issue       = issue_w;
    assign sb.stall_count = stall_count_q;
endmodule
